c17_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for the c17 NAND2 combinational core.
- Generates pseudo-random 5-bit input vectors with an LFSR and drives them onto the core's N1,N2,N3,N6,N7 inputs.
- Waits a programmable settle time, then compacts the N22/N23 responses into a 16-bit MISR.
- At the end of a run, compares the signature against a golden value. The core is instantiated beside this block, not inside it.

---
 rtl/c17_bist_pkg.sv | 39 +++
 rtl/c17_bist_if.sv | 27 ++
 rtl/c17_bist_misr.sv | 35 +++
 rtl/c17_bist_ctrl.sv | 155 +++++++++++++++
 tb/tb_c17_bist_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/c17_bist_pkg.sv
// c17_bist_pkg: shared definitions for the c17 BIST sequencer.
// Holds the FSM state encoding, the LFSR/MISR widths and tap positions,
// the default LFSR seed, and the one-step LFSR/MISR update functions.
package c17_bist_pkg;

  localparam int LFSR_W = 5;
  localparam int MISR_W = 16;

  localparam int LFSR_TAP_HI = 4;
  localparam int LFSR_TAP_LO = 2;

  localparam int MISR_TAP_A = 15;
  localparam int MISR_TAP_B = 13;
  localparam int MISR_TAP_C = 12;
  localparam int MISR_TAP_D = 10;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 5'b00001;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Fibonacci LFSR step; period 31, never reaches all-zero from a nonzero seed.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

  // MISR step: shift with feedback, then fold in the two response bits.
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                  input logic [1:0]        d);
    return {s[MISR_W-2:0], s[MISR_TAP_A] ^ s[MISR_TAP_B] ^ s[MISR_TAP_C] ^ s[MISR_TAP_D]}
           ^ {14'b0, d};
  endfunction

endpackage

// File: rtl/c17_bist_if.sv
// c17_bist_if: run control, core vector/response and result signals of the
// c17 BIST sequencer.
//   master: start, golden_sig, core_out driven; results observed.
//   slave : the sequencer (c17_bist_ctrl).
interface c17_bist_if
  import c17_bist_pkg::*;
  ;
  logic              start;
  logic [MISR_W-1:0] golden_sig;
  logic [LFSR_W-1:0] core_in;
  logic [1:0]        core_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;
  logic [15:0]       pattern_cnt;

  modport master (
    output start, golden_sig, core_out,
    input  core_in, busy, done, pass, signature, pattern_cnt
  );

  modport slave (
    input  start, golden_sig, core_out,
    output core_in, busy, done, pass, signature, pattern_cnt
  );
endinterface

// File: rtl/c17_bist_misr.sv
// c17_bist_misr: 16-bit multiple-input signature register.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear to zero (wins over en)
//   en        : fold din into the signature this cycle
//   din       : 2-bit core response
//   sig       : current signature
//   sig_next  : signature after folding din (used to judge pass at run end)
module c17_bist_misr
  import c17_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [1:0]        din,
  output logic [MISR_W-1:0] sig,
  output logic [MISR_W-1:0] sig_next
);

  assign sig_next = misr_next(sig, din);

  // Signature register: clear, compact or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= 16'h0000;
    end else if (clr) begin
      sig <= 16'h0000;
    end else if (en) begin
      sig <= sig_next;
    end else begin
      sig <= sig;
    end
  end

endmodule

// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: BIST sequencer for an external c17 core.
// Drives LFSR vectors on core_in, waits SETTLE_CYCLES, compacts core_out
// into a MISR, and compares the final signature against golden_sig.
//   clk, rst : clock, synchronous active-high reset
//   bus      : c17_bist_if.slave (start, golden_sig, core_in, core_out,
//              busy, done, pass, signature, pattern_cnt)
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int                NUM_PATTERNS  = 32,
  parameter int                SETTLE_CYCLES = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = DEFAULT_SEED
) (
  input  logic      clk,
  input  logic      rst,
  c17_bist_if.slave bus
);

  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [15:0] LAST_CNT    = 16'(NUM_PATTERNS);

  state_t            state;
  state_t            next_state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] core_in;
  logic [7:0]        settle_cnt;
  logic [15:0]       pattern_cnt;
  logic [15:0]       cnt_inc;
  logic              busy;
  logic              done;
  logic              pass;
  logic              misr_clr;
  logic              misr_en;
  logic [MISR_W-1:0] sig;
  logic [MISR_W-1:0] sig_next;

  assign cnt_inc = pattern_cnt + 16'd1;

  c17_bist_misr u_misr (
    .clk      (clk),
    .rst      (rst),
    .clr      (misr_clr),
    .en       (misr_en),
    .din      (bus.core_out),
    .sig      (sig),
    .sig_next (sig_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and MISR control.
  always_comb begin
    next_state = state;
    misr_clr   = 1'b0;
    misr_en    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          next_state = ST_APPLY;
          misr_clr   = 1'b1;
        end else begin
          next_state = state;
        end
      end
      ST_APPLY: begin
        if (SETTLE_LOAD != 8'd0) begin
          next_state = ST_SETTLE;
        end else begin
          next_state = ST_CAPTURE;
        end
      end
      ST_SETTLE: begin
        // Counter was loaded with SETTLE_CYCLES; value 1 is the last settle cycle.
        if (settle_cnt == 8'd1) begin
          next_state = ST_CAPTURE;
        end else begin
          next_state = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        misr_en = 1'b1;
        if (cnt_inc == LAST_CNT) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_APPLY;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: LFSR, applied vector, settle counter, pattern count, pass flag, status.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= LFSR_SEED;
      core_in     <= 5'b00000;
      settle_cnt  <= 8'd0;
      pattern_cnt <= 16'd0;
      pass        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CAPTURE);
      // done is asserted once DONE has been held for a cycle and drops on the
      // same edge that accepts a restart.
      done <= (state == ST_DONE) && (next_state == ST_DONE);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_IDLE) begin
            core_in <= 5'b00000;
          end
          if (bus.start) begin
            lfsr        <= LFSR_SEED;
            pattern_cnt <= 16'd0;
            pass        <= 1'b0;
          end
        end
        ST_APPLY: begin
          core_in    <= lfsr;
          lfsr       <= lfsr_next(lfsr);
          settle_cnt <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 8'd1;
        end
        ST_CAPTURE: begin
          pattern_cnt <= cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            pass <= (sig_next == bus.golden_sig);
          end
        end
        default: begin
          core_in <= 5'b00000;
        end
      endcase
    end
  end

  assign bus.core_in     = core_in;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass        = pass;
  assign bus.signature   = sig;
  assign bus.pattern_cnt = pattern_cnt;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench for c17_bist_ctrl. Five sequencers with different
// pattern counts / settle times run side by side; each sees a c17 model,
// either zero-delay or with a 3-clock response delay.
module tb_c17_bist_ctrl;

  logic            clk;
  logic            rst;
  logic [4:0]       start_v;
  logic [4:0][15:0] golden_v;
  logic [4:0][4:0]  cin_v;
  logic [4:0]       busy_v;
  logic [4:0]       done_v;
  logic [4:0]       pass_v;
  logic [4:0][15:0] sig_v;
  logic [4:0][15:0] cnt_v;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] vecs[$];

  // instance:            4       3       2       1      0
  localparam logic [4:0][15:0] NP_T  = {16'd32, 16'd32, 16'd32, 16'd2, 16'd1};
  localparam logic [4:0][7:0]  ST_T  = {8'd0,   8'd3,   8'd0,   8'd1,  8'd1};
  localparam logic [4:0]       DLY_T = 5'b11000;

  // c17 reference: six NAND2 gates. v = {N1,N2,N3,N6,N7}; result {N22,N23}.
  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[4] & v[2]);
    n11 = ~(v[2] & v[1]);
    n16 = ~(v[3] & n11);
    n19 = ~(n11 & v[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  function automatic logic [4:0] lfsr_step(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  // Whole-run signature: walk the vector sequence, feed c17 responses into a
  // shift-with-feedback register (taps 15,13,12,10 as a parity mask).
  function automatic logic [15:0] ref_sig(input int np, input logic [4:0] seed);
    logic [15:0] s;
    logic [4:0]  v;
    s = 16'h0000;
    v = seed;
    for (int k = 0; k < np; k++) begin
      s = ((s << 1) | {15'd0, ^(s & 16'hB400)}) ^ {14'd0, c17(v)};
      v = lfsr_step(v);
    end
    return s;
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_dut
    c17_bist_if bus ();
    logic [4:0] d1, d2, d3;

    c17_bist_ctrl #(
      .NUM_PATTERNS  (int'(NP_T[g])),
      .SETTLE_CYCLES (int'(ST_T[g])),
      .LFSR_SEED     (5'b00001)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    always @(posedge clk) begin
      d1 <= bus.core_in;
      d2 <= d1;
      d3 <= d2;
    end

    assign bus.start      = start_v[g];
    assign bus.golden_sig = golden_v[g];
    assign bus.core_out   = DLY_T[g] ? c17(d3) : c17(bus.core_in);
    assign cin_v[g]       = bus.core_in;
    assign busy_v[g]      = bus.busy;
    assign done_v[g]      = bus.done;
    assign pass_v[g]      = bus.pass;
    assign sig_v[g]       = bus.signature;
    assign cnt_v[g]       = bus.pattern_cnt;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start instance i and follow it until done (or budget runs out).
  // poke>0 pulses start again after edge 'poke' while the run is in flight.
  task automatic run(input int i, input int budget, input int poke,
                     output int t_done, output int n_busy,
                     output logic [15:0] sig0, output logic dn0);
    logic [15:0] prev;
    vecs.delete();
    t_done = -1;
    n_busy = 0;
    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    sig0 = sig_v[i];
    dn0  = done_v[i];
    prev = cnt_v[i];
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      start_v[i] = 1'b0;
      if (busy_v[i]) n_busy++;
      if (cnt_v[i] != prev) begin
        vecs.push_back(cin_v[i]);
        prev = cnt_v[i];
      end
      if (done_v[i]) begin
        t_done = k;
        break;
      end
      if (k == poke) start_v[i] = 1'b1;
    end
  endtask

  initial begin
    int          td, nb, zeros, diffs, poke;
    logic [15:0] s0, exp32, g;
    logic        dn0;
    logic [4:0]  m;

    rst      = 1'b1;
    start_v  = 5'b00000;
    golden_v = '0;
    exp32    = ref_sig(32, 5'b00001);
    repeat (4) @(posedge clk);
    #1;
    check("rst_core_in", cin_v[0], 5'b00000);
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_done", done_v[0], 1'b0);
    check("rst_pass", pass_v[0], 1'b0);
    check("rst_sig", sig_v[0], 16'h0000);
    check("rst_cnt", cnt_v[0], 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat ($urandom_range(4, 1)) @(posedge clk);

    // Single pattern, one settle cycle.
    golden_v[0] = 16'h0001;
    run(0, 20, 0, td, nb, s0, dn0);
    check("t1_done_time", td, 4);
    check("t1_sig", sig_v[0], ref_sig(1, 5'b00001));
    check("t1_sig_const", sig_v[0], 16'h0001);
    check("t1_pass", pass_v[0], 1'b1);
    check("t1_vec0", vecs[0], 5'b00001);
    check("t1_cnt", cnt_v[0], 16'd1);

    // Two patterns; matching then non-matching golden.
    golden_v[1] = 16'h0002;
    run(1, 20, 0, td, nb, s0, dn0);
    check("t2_done_time", td, 7);
    check("t2_sig", sig_v[1], 16'h0002);
    check("t2_pass", pass_v[1], 1'b1);
    check("t2_vec0", vecs[0], 5'b00001);
    check("t2_vec1", vecs[1], 5'b00010);
    golden_v[1] = 16'h0003;
    run(1, 20, 0, td, nb, s0, dn0);
    check("t2b_done_time", td, 7);
    check("t2b_pass", pass_v[1], 1'b0);
    golden_v[1] = 16'h0002;
    repeat (3) @(posedge clk);
    #1;
    check("t2b_golden_late", pass_v[1], 1'b0);
    check("t2b_done_held", done_v[1], 1'b1);

    // 32 patterns, no settle: timing, LFSR sequence and wrap.
    golden_v[2] = exp32;
    run(2, 200, 0, td, nb, s0, dn0);
    check("t3_done_time", td, 65);
    check("t3_busy_cycles", nb, 64);
    check("t3_cnt", cnt_v[2], 16'd32);
    check("t3_sig", sig_v[2], exp32);
    check("t3_pass", pass_v[2], 1'b1);
    zeros = 0;
    diffs = 0;
    m = 5'b00001;
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k] == 5'b00000) zeros++;
      if (vecs[k] !== m) diffs++;
      m = lfsr_step(m);
    end
    check("t3_nvec", vecs.size(), 32);
    check("t3_zero_vecs", zeros, 0);
    check("t3_seq_diffs", diffs, 0);
    check("t3_vec32", vecs[31], 5'b00001);

    // Restart from DONE with a stray start mid-run.
    poke = $urandom_range(60, 2);
    run(2, 200, poke, td, nb, s0, dn0);
    check("t5_done_drop", dn0, 1'b0);
    check("t5_sig_clear", s0, 16'h0000);
    check("t5_done_time", td, 65);
    check("t5_busy_cycles", nb, 64);
    check("t5_sig", sig_v[2], exp32);
    check("t5_pass", pass_v[2], 1'b1);
    g = 16'($urandom);
    if (g == exp32) g = g ^ 16'h0001;
    golden_v[2] = g;
    run(2, 200, 0, td, nb, s0, dn0);
    check("t5_rand_golden_pass", pass_v[2], 1'b0);
    check("t5_rand_golden_sig", sig_v[2], exp32);

    // Reset during SETTLE of pattern 5 (3 settle cycles, delayed core).
    golden_v[3] = exp32;
    @(negedge clk);
    start_v[3] = 1'b1;
    @(posedge clk);
    #1;
    start_v[3] = 1'b0;
    td = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (cnt_v[3] == 16'd4) begin
        td = k;
        break;
      end
    end
    check("t4_reach_cnt4", (td >= 0), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("t4_busy_mid", busy_v[3], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t4_core_in", cin_v[3], 5'b00000);
    check("t4_busy", busy_v[3], 1'b0);
    check("t4_done", done_v[3], 1'b0);
    check("t4_sig", sig_v[3], 16'h0000);
    check("t4_cnt", cnt_v[3], 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t4_idle_busy", busy_v[3], 1'b0);
    run(3, 400, 0, td, nb, s0, dn0);
    check("t6_done_time", td, 161);
    check("t6_sig_delayed", sig_v[3], exp32);
    check("t6_pass_delayed", pass_v[3], 1'b1);

    // Delayed core with no settle time must fail.
    golden_v[4] = exp32;
    run(4, 200, 0, td, nb, s0, dn0);
    check("t6b_done_time", td, 65);
    check("t6b_pass", pass_v[4], 1'b0);
    check("t6b_sig_differs", (sig_v[4] !== exp32), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
